instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Multi-cycle fetch sequencer that drives the instruction register's write side. It holds the PC and runs a request/acknowledge read from instruction memory at PC, with variable wait states. It presents the returned word with a one-cycle IRWrite pulse, then advances PC by 4. It sits between the main control FSM (fetch_start, pc_load) and the instruction memory port, and feeds the IR's instruction_in and IRWrite inputs.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- MAX_WAIT, 15, maximum REQ cycles allowed without mem_ack before a fault (1..255)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_start  in  1  control requests the next fetch; sampled only in IDLE
- pc_load  in  1  load pc_next_in into PC (branch/jump); sampled in IDLE and FAULT
- pc_next_in  in  32  redirect target
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  read address; equals pc
- mem_ack  in  1  memory has valid data on mem_rdata this cycle
- mem_rdata  in  32  read data
- IRWrite  out  1  one-cycle write enable to the IR
- instr_word  out  32  instruction to the IR's instruction_in
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, combinational, mod 2^32
- busy  out  1  high in REQ and LOAD
- fetch_fault  out  1  high in FAULT

## Operation
- FSM states: IDLE, REQ, LOAD, FAULT.
- IDLE:
  - pc_load=1: pc <= pc_next_in; stay IDLE. pc_load has priority, so a simultaneous fetch_start is dropped and must be reasserted.
  - fetch_start=1 with pc[1:0]!=0: go to FAULT; no mem_req is issued.
  - fetch_start=1 with aligned pc: go to REQ and clear the wait counter.
- REQ:
  - mem_req=1; mem_addr=pc, held stable.
  - mem_ack=1: instr_word <= mem_rdata; go to LOAD.
  - Otherwise the wait counter increments. If MAX_WAIT REQ cycles elapse without mem_ack, go to FAULT. An ack in the MAX_WAIT-th cycle is accepted (ack wins).
- LOAD:
  - IRWrite=1; instr_word stable.
  - On the edge ending LOAD: pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0); go to IDLE.
- FAULT:
  - fetch_fault=1; fetch_start ignored.
  - pc_load=1: pc <= pc_next_in; go to IDLE.
- mem_ack outside REQ is ignored. mem_rdata is sampled only on the ack edge.
- pc_load outside IDLE and FAULT is ignored.
- instr_word keeps its last captured value outside LOAD.

## Timing
- Reset (async assert): state=IDLE, pc=RESET_PC, instr_word=0, mem_req=0, IRWrite=0, busy=0, fetch_fault=0.
- Reset mid-REQ or mid-LOAD: outputs drop immediately; no IRWrite, no PC increment.
- All outputs except pc_plus4 are registered or decoded from state only; there is no combinational path from mem_ack.
- Zero-wait memory (ack in the first REQ cycle): fetch_start sampled at edge E0 → REQ during cycle 1 → LOAD during cycle 2 (IRWrite=1) → IDLE at E3 with pc+4. The IR captures instr_word at E3.
- Each additional wait state adds one REQ cycle. Back-to-back fetches: fetch_start is sampled again in the IDLE cycle after LOAD, giving a minimum of 3 cycles per instruction.

## Structure
- Shared package mips_pkg:
  - fetch state enum (IDLE/REQ/LOAD/FAULT)
  - INSTR_W=32
  - default RESET_PC constant
- One sub-module, fetch_wait_timer: an 8-bit counter with clear, enable and an expired flag at MAX_WAIT, instantiated for the REQ timeout.
- The FSM, PC register and instr_word register stay in the top.

## Test plan
- Reset, then fetch_start with ack on the first REQ cycle and mem_rdata=32'h2008_0005 → mem_addr=0, IRWrite high exactly one cycle with instr_word=32'h2008_0005, pc=4 afterward.
- Ack after 3 wait states at pc=32'h40 → mem_req high for 4 cycles with mem_addr stable at 32'h40; one IRWrite; pc=32'h44.
- pc_load=1 with pc_next_in=32'h100 in the same cycle as fetch_start → pc=32'h100, no mem_req. Then a fetch reads address 32'h100.
- No ack for MAX_WAIT=15 cycles → fetch_fault=1, IRWrite never asserted. An ack on cycle 15 in a separate run → normal LOAD.
- pc_load to 32'h102, then fetch_start → FAULT with no mem_req. A following pc_load to 32'h0 → IDLE, fetch_fault=0.
- rst_n asserted during the REQ wait → mem_req low immediately, pc=RESET_PC, no IRWrite. Also a fetch at pc=32'hFFFF_FFFC → pc wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-path types and constants
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, REQ, LOAD, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: saturating 8-bit wait-state counter flagging the last allowed REQ cycle
module fetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [7:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (en && count != 8'hFF) count <= count + 8'd1;
    end
    // count holds the number of REQ cycles already elapsed, so this is the MAX_WAIT-th cycle
    assign expired = count >= 8'(MAX_WAIT - 1);
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC holder and req/ack fetch sequencer driving the IR write side
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_start,
    input  logic               pc_load,
    input  logic [INSTR_W-1:0] pc_next_in,
    output logic               mem_req,
    output logic [INSTR_W-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               IRWrite,
    output logic [INSTR_W-1:0] instr_word,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic               busy,
    output logic               fetch_fault
);
    fetch_state_t state;
    logic expired;
    fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .clr(state != REQ),
        .en(state == REQ && !mem_ack),
        .expired(expired)
    );
    assign mem_addr = pc;
    assign pc_plus4 = pc + 32'd4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_word  <= '0;
            mem_req     <= 1'b0;
            IRWrite     <= 1'b0;
            busy        <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // a redirect wins over a simultaneous fetch request
                    if (pc_load) pc <= pc_next_in;
                    else if (fetch_start && pc[1:0] != 2'b00) begin
                        state       <= FAULT;
                        fetch_fault <= 1'b1;
                    end else if (fetch_start) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        instr_word <= mem_rdata;
                        state      <= LOAD;
                        mem_req    <= 1'b0;
                        IRWrite    <= 1'b1;
                    end else if (expired) begin
                        state       <= FAULT;
                        mem_req     <= 1'b0;
                        busy        <= 1'b0;
                        fetch_fault <= 1'b1;
                    end
                end
                LOAD: begin
                    pc      <= pc_plus4;
                    state   <= IDLE;
                    IRWrite <= 1'b0;
                    busy    <= 1'b0;
                end
                FAULT: begin
                    if (pc_load) begin
                        pc          <= pc_next_in;
                        state       <= IDLE;
                        fetch_fault <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scenario tasks plus a scoreboard of expected IR words
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_next_in = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        IRWrite;
    logic [31:0] instr_word;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        fetch_fault;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    instruction_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
        .pc_next_in(pc_next_in), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .IRWrite(IRWrite),
        .instr_word(instr_word), .pc(pc), .pc_plus4(pc_plus4), .busy(busy),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && IRWrite) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_irwrite: instr_word=%h with no fetch outstanding", instr_word);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (instr_word !== e) begin
                    miscompares++;
                    $display("FAIL ir_word: got %h expected %h", instr_word, e);
                end
            end
        end
    end

    task automatic do_pc_load(input logic [31:0] target);
        @(posedge clk); #1;
        pc_load = 1'b1;
        pc_next_in = target;
        @(posedge clk); #1;
        pc_load = 1'b0;
    endtask

    // acks in the (waits+1)-th REQ cycle; waits >= 15 never acks
    task automatic run_fetch(input logic [31:0] data, input int waits,
                             output int req_cycles, output logic [31:0] addr,
                             output bit addr_ok, output int irw);
        req_cycles = 0;
        addr_ok = 1'b1;
        addr = 'x;
        irw = 0;
        if (waits < 15) exp_q.push_back(data);
        @(posedge clk); #1;
        fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!mem_req) break;
            if (c == 0) addr = mem_addr;
            else if (mem_addr !== addr) addr_ok = 1'b0;
            req_cycles++;
            mem_ack = (c == waits);
            mem_rdata = (c == waits) ? data : 32'hDEAD_BEEF;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        irw += int'(IRWrite);
        repeat (2) begin
            @(negedge clk);
            irw += int'(IRWrite);
        end
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if ({mem_req, IRWrite, busy, fetch_fault} !== 4'b0 || pc !== 32'h0 || instr_word !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: req=%b irw=%b busy=%b fault=%b pc=%h iw=%h expected all zero",
                     mem_req, IRWrite, busy, fetch_fault, pc, instr_word);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (pc_plus4 !== 32'h4) begin
            miscompares++;
            $display("FAIL reset_pc_plus4: got %h expected 00000004", pc_plus4);
        end
    endtask

    task automatic test_zero_wait;
        int rc, irw; logic [31:0] a; bit ok;
        run_fetch(32'h2008_0005, 0, rc, a, ok, irw);
        vectors++;
        if (rc !== 1 || a !== 32'h0 || irw !== 1 || pc !== 32'h4) begin
            miscompares++;
            $display("FAIL zero_wait: req=%0d addr=%h irw=%0d pc=%h expected 1 0 1 00000004", rc, a, irw, pc);
        end
    endtask

    task automatic test_wait_states;
        int rc, irw; logic [31:0] a; bit ok;
        do_pc_load(32'h40);
        run_fetch(32'h8C01_0010, 3, rc, a, ok, irw);
        vectors++;
        if (rc !== 4 || a !== 32'h40 || !ok || irw !== 1 || pc !== 32'h44) begin
            miscompares++;
            $display("FAIL wait3: req=%0d addr=%h stable=%0d irw=%0d pc=%h expected 4 40 1 1 44", rc, a, ok, irw, pc);
        end
    endtask

    task automatic test_load_priority;
        int rc, irw; logic [31:0] a; bit ok;
        @(posedge clk); #1;
        pc_load = 1'b1; fetch_start = 1'b1; pc_next_in = 32'h100;
        @(posedge clk); #1;
        pc_load = 1'b0; fetch_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || pc !== 32'h100) begin
            miscompares++;
            $display("FAIL load_priority: req=%b busy=%b pc=%h expected 0 0 100", mem_req, busy, pc);
        end
        run_fetch(32'h0000_0020, 1, rc, a, ok, irw);
        vectors++;
        if (a !== 32'h100 || irw !== 1 || pc !== 32'h104) begin
            miscompares++;
            $display("FAIL fetch_after_load: addr=%h irw=%0d pc=%h expected 100 1 104", a, irw, pc);
        end
    endtask

    task automatic test_timeout;
        int rc, irw; logic [31:0] a; bit ok;
        do_pc_load(32'h200);
        run_fetch(32'h0, 99, rc, a, ok, irw);
        vectors++;
        if (rc !== 15 || irw !== 0 || fetch_fault !== 1'b1 || busy !== 1'b0 || pc !== 32'h200) begin
            miscompares++;
            $display("FAIL timeout: req=%0d irw=%0d fault=%b busy=%b pc=%h expected 15 0 1 0 200", rc, irw, fetch_fault, busy, pc);
        end
        do_pc_load(32'h300);
        @(negedge clk);
        vectors++;
        if (fetch_fault !== 1'b0 || pc !== 32'h300) begin
            miscompares++;
            $display("FAIL fault_recover: fault=%b pc=%h expected 0 300", fetch_fault, pc);
        end
        run_fetch(32'hABCD_1234, 14, rc, a, ok, irw);
        vectors++;
        if (rc !== 15 || irw !== 1 || fetch_fault !== 1'b0 || pc !== 32'h304) begin
            miscompares++;
            $display("FAIL ack_last_cycle: req=%0d irw=%0d fault=%b pc=%h expected 15 1 0 304", rc, irw, fetch_fault, pc);
        end
    endtask

    task automatic test_misaligned;
        int req_seen = 0;
        do_pc_load(32'h102);
        @(posedge clk); #1 fetch_start = 1'b1;
        @(posedge clk); #1 fetch_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            req_seen += int'(mem_req);
        end
        vectors++;
        if (fetch_fault !== 1'b1 || req_seen !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned: fault=%b req_cycles=%0d busy=%b expected 1 0 0", fetch_fault, req_seen, busy);
        end
        do_pc_load(32'h0);
        @(negedge clk);
        vectors++;
        if (fetch_fault !== 1'b0 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL misaligned_recover: fault=%b pc=%h expected 0 0", fetch_fault, pc);
        end
    endtask

    task automatic test_reset_mid_req;
        do_pc_load(32'h80);
        @(posedge clk); #1 fetch_start = 1'b1;
        @(posedge clk); #1 fetch_start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL req_before_reset: req=%b busy=%b expected 1 1", mem_req, busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || pc !== 32'h0 || IRWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: req=%b busy=%b pc=%h irw=%b expected 0 0 0 0", mem_req, busy, pc, IRWrite);
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (IRWrite !== 1'b0 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL after_reset: irw=%b pc=%h expected 0 0", IRWrite, pc);
        end
    endtask

    task automatic test_wrap;
        int rc, irw; logic [31:0] a; bit ok;
        do_pc_load(32'hFFFF_FFFC);
        @(negedge clk);
        vectors++;
        if (pc_plus4 !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_plus4_wrap: got %h expected 00000000", pc_plus4);
        end
        run_fetch(32'h0800_0000, 2, rc, a, ok, irw);
        vectors++;
        if (a !== 32'hFFFF_FFFC || irw !== 1 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_fetch: addr=%h irw=%0d pc=%h expected fffffffc 1 0", a, irw, pc);
        end
    endtask

    task automatic test_back_to_back;
        int rc, irw; logic [31:0] a; bit ok;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            d = $urandom;
            run_fetch(d, i, rc, a, ok, irw);
            vectors++;
            if (a !== 32'(4 * i) || rc !== i + 1 || irw !== 1 || pc !== 32'(4 * i + 4)) begin
                miscompares++;
                $display("FAIL back_to_back%0d: addr=%h req=%0d irw=%0d pc=%h expected %h %0d 1 %h",
                         i, a, rc, irw, pc, 4 * i, i + 1, 4 * i + 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_load_priority();
        test_timeout();
        test_misaligned();
        test_reset_mid_req();
        test_wrap();
        test_back_to_back();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected words never written, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
